// File: rtl/bcd_display_if.sv
// Bus between the ALU result stage and the BCD display driver: captured
// result in, conversion status, latched BCD word and the multiplexed display out.
interface bcd_display_if #(
  parameter int IN_WIDTH = 16
);
  logic [IN_WIDTH-1:0] value;
  logic                neg;
  logic                load;
  logic                busy;
  logic [15:0]         bcd;
  logic [0:6]          sevenseg;
  logic [3:0]          anode;

  modport master (
    output value, neg, load,
    input  busy, bcd, sevenseg, anode
  );

  modport slave (
    input  value, neg, load,
    output busy, bcd, sevenseg, anode
  );
endinterface

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter feeding a time-multiplexed
// common-anode 4-digit seven-segment display (segments and anodes active-low).
module bcd_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int IN_WIDTH    = 16
) (
  input logic          clk,
  input logic          rst,
  bcd_display_if.slave bus
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);
  localparam logic [REF_W-1:0] LAST_REF  = REF_W'(REFRESH_DIV - 1);

  localparam logic [0:6] SEG_ZERO  = 7'b0000001;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              r_state;
  logic                r_busy;
  logic [IN_WIDTH-1:0] r_bin;
  logic [15:0]         r_scratch;
  logic [CNT_W-1:0]    r_iter;
  logic                r_sign_cap, r_ovf_cap;
  logic [15:0]         r_bcd;
  logic                r_sign, r_ovf;
  logic [REF_W-1:0]    r_refresh;
  logic [1:0]          r_digit;
  logic [3:0]          r_anode;
  logic [0:6]          r_seg;

  logic [15:0] w_adj;
  logic        w_ovf_in;
  logic        w_wrap;
  logic [1:0]  w_digit_nx;
  logic [15:0] w_bcd_nx;
  logic        w_sign_nx, w_ovf_nx;

  function automatic logic [15:0] dabble_adjust(input logic [15:0] x);
    logic [15:0] y;
    y = x;
    for (int i = 0; i < 4; i++)
      if (x[4*i +: 4] >= 4'd5) y[4*i +: 4] = x[4*i +: 4] + 4'd3;
    return y;
  endfunction

  function automatic logic [0:6] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_ZERO;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Overflow dash beats the sign minus, which beats leading-zero blanking.
  function automatic logic [0:6] glyph(input logic [1:0] idx, input logic [15:0] bcd,
                                       input logic sign, input logic ovf);
    logic blank;
    blank = (idx != 2'd0) && ((bcd >> {idx, 2'b00}) == 16'd0);
    if (ovf)                      return SEG_DASH;
    else if (sign && idx == 2'd3) return SEG_DASH;
    else if (blank)               return SEG_BLANK;
    else                          return seg_decode(bcd[{idx, 2'b00} +: 4]);
  endfunction

  // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_adj      = dabble_adjust(r_scratch);
    w_ovf_in   = (32'(bus.value) > 32'd9999) || (bus.neg && (32'(bus.value) > 32'd999));
    w_wrap     = (r_refresh == LAST_REF);
    w_digit_nx = w_wrap ? r_digit + 2'd1 : r_digit;
    w_bcd_nx   = (r_state == DONE) ? r_scratch  : r_bcd;
    w_sign_nx  = (r_state == DONE) ? r_sign_cap : r_sign;
    w_ovf_nx   = (r_state == DONE) ? r_ovf_cap  : r_ovf;
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_bin      <= '0;
      r_scratch  <= '0;
      r_iter     <= '0;
      r_sign_cap <= 1'b0;
      r_ovf_cap  <= 1'b0;
      r_bcd      <= '0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.load) begin
          r_bin      <= bus.value;
          r_scratch  <= '0;
          r_iter     <= '0;
          r_sign_cap <= bus.neg;
          r_ovf_cap  <= w_ovf_in;
          r_busy     <= 1'b1;
          r_state    <= CONV;
        end
        CONV: begin
          // Only the low four digits are kept; carries never flow downward.
          r_scratch <= (w_adj << 1) | {15'd0, r_bin[IN_WIDTH-1]};
          r_bin     <= r_bin << 1;
          r_iter    <= r_iter + CNT_W'(1);
          if (r_iter == LAST_ITER) r_state <= DONE;
        end
        DONE: begin
          r_bcd   <= r_scratch;
          r_sign  <= r_sign_cap;
          r_ovf   <= r_ovf_cap;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Segments are computed from next-cycle digit and data so they land with the anode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refresh <= '0;
      r_digit   <= 2'd0;
      r_anode   <= 4'b1110;
      r_seg     <= SEG_ZERO;
    end else begin
      r_refresh <= w_wrap ? '0 : r_refresh + REF_W'(1);
      r_digit   <= w_digit_nx;
      r_anode   <= ~(4'b0001 << w_digit_nx);
      r_seg     <= glyph(w_digit_nx, w_bcd_nx, w_sign_nx, w_ovf_nx);
    end
  end

  assign bus.busy     = r_busy;
  assign bus.bcd      = r_bcd;
  assign bus.sevenseg = r_seg;
  assign bus.anode    = r_anode;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver: an arithmetic reference model is
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_bcd_display_driver;

  localparam int RD       = 4;
  localparam int W        = 16;
  localparam int CONV_LEN = W + 1;
  localparam logic [0:6] DASH  = 7'b1111110;
  localparam logic [0:6] BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bcd_display_if #(.IN_WIDTH(W)) bus ();

  bcd_display_driver #(.REFRESH_DIV(RD), .IN_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  logic [0:6] glyph_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_busy, m_cap_val, m_val, m_ref, m_digit;
  bit m_cap_neg, m_sign, m_ovf;

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] bcd_of(input int v);
    return 32'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  function automatic logic [3:0] anode_of(input int d);
    return 4'b1111 ^ (4'b0001 << d);
  endfunction

  function automatic logic [0:6] model_seg(input int d, input int v, input bit sign, input bit ovf);
    if (ovf) return DASH;
    if (sign && d == 3) return DASH;
    if (d > 0 && v < pow10(d)) return BLANK;
    return glyph_tab[(v / pow10(d)) % 10];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_cap_val <= 0; m_cap_neg <= 1'b0;
      m_val <= 0; m_sign <= 1'b0; m_ovf <= 1'b0;
      m_ref <= 0; m_digit <= 0;
    end else begin
      if (m_busy == 0) begin
        if (bus.load) begin
          m_cap_val <= int'(bus.value);
          m_cap_neg <= bus.neg;
          m_busy    <= CONV_LEN;
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_val  <= m_cap_val % 10000;
          m_sign <= m_cap_neg;
          m_ovf  <= (m_cap_val > 9999) || (m_cap_neg && m_cap_val > 999);
        end
      end
      if (m_ref == RD - 1) begin
        m_ref   <= 0;
        m_digit <= (m_digit + 1) % 4;
      end else begin
        m_ref <= m_ref + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",     32'(bus.busy),     32'(m_busy != 0));
      check("bcd",      32'(bus.bcd),      bcd_of(m_val));
      check("anode",    32'(bus.anode),    32'(anode_of(m_digit)));
      check("sevenseg", 32'(bus.sevenseg), 32'(model_seg(m_digit, m_val, m_sign, m_ovf)));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_load(input int v, input bit n, input int relo_cyc, input int relo_val,
                          output int len);
    bus.value = W'(v);
    bus.neg   = n;
    bus.load  = 1'b1;
    @(posedge clk);
    #2 bus.load = 1'b0;
    len = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.busy) break;
      len++;
      bus.load = (c == relo_cyc);
      if (c == relo_cyc) bus.value = W'(relo_val);
    end
    bus.load = 1'b0;
  endtask

  task automatic scan_expect(input string name, input logic [0:6] s0, input logic [0:6] s1,
                             input logic [0:6] s2, input logic [0:6] s3);
    logic [0:6] exp_seg [4];
    logic [3:0] exp_an [4];
    logic [3:0] prev;
    bit found;
    exp_seg = '{s0, s1, s2, s3};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    found = 1'b0;
    prev  = bus.anode;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.anode == 4'b1110 && prev == 4'b0111) found = 1'b1;
      else prev = bus.anode;
    end
    check({name, "_sync"}, 32'(found), 32'd1);
    for (int j = 0; j < 4 * RD; j++) begin
      if (j > 0) @(negedge clk);
      check({name, "_anode"}, 32'(bus.anode),    32'(exp_an[j / RD]));
      check({name, "_seg"},   32'(bus.sevenseg), 32'(exp_seg[j / RD]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    bus.value = '0;
    bus.neg   = 1'b0;
    bus.load  = 1'b0;

    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_anode", 32'(bus.anode),    32'(4'b1110));
    check("rst_seg",   32'(bus.sevenseg), 32'(7'b0000001));
    check("rst_bcd",   32'(bus.bcd),      32'h0000);
    check("rst_busy",  32'(bus.busy),     32'd0);

    run_load(1234, 1'b0, -1, 0, len);
    check("conv_busy_len", 32'(len), 32'(CONV_LEN));
    check("conv_bcd", 32'(bus.bcd), 32'h1234);
    scan_expect("scan1234", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);

    run_load(7, 1'b0, -1, 0, len);
    check("blank7_bcd", 32'(bus.bcd), 32'h0007);
    scan_expect("blank7", 7'b0001111, BLANK, BLANK, BLANK);

    run_load(5, 1'b1, -1, 0, len);
    scan_expect("neg5", 7'b0100100, BLANK, BLANK, DASH);

    run_load(10000, 1'b0, -1, 0, len);
    check("ovf10000_bcd", 32'(bus.bcd), 32'h0000);
    scan_expect("ovf10000", DASH, DASH, DASH, DASH);

    run_load(1000, 1'b1, -1, 0, len);
    check("ovf_neg1000_bcd", 32'(bus.bcd), 32'h1000);
    scan_expect("ovf_neg1000", DASH, DASH, DASH, DASH);

    run_load(42, 1'b0, 2, 99, len);
    check("lockout_busy_len", 32'(len), 32'(CONV_LEN));
    check("lockout_bcd", 32'(bus.bcd), 32'h0042);
    repeat (3) @(negedge clk);
    check("lockout_no_requeue", 32'(bus.busy), 32'd0);

    // Reset in the fifth cycle of conversion.
    @(posedge clk);
    #2 bus.value = W'(9999); bus.load = 1'b1;
    @(posedge clk);
    #2 bus.load = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy",  32'(bus.busy),     32'd0);
    check("midrst_bcd",   32'(bus.bcd),      32'h0000);
    check("midrst_anode", 32'(bus.anode),    32'(4'b1110));
    check("midrst_seg",   32'(bus.sevenseg), 32'(7'b0000001));
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("midrst_no_stale_bcd",  32'(bus.bcd),  32'h0000);
    check("midrst_no_stale_busy", 32'(bus.busy), 32'd0);

    // Randomised loads, including some issued while a conversion is running.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       bus.value = W'($urandom_range(0, 9));
        1:       bus.value = W'($urandom_range(0, 999));
        2:       bus.value = W'($urandom_range(0, 9999));
        default: bus.value = W'($urandom_range(0, 65535));
      endcase
      bus.neg  = 1'($urandom_range(0, 1));
      bus.load = 1'b1;
      @(posedge clk);
      #2 bus.load = 1'b0;
      repeat ($urandom_range(0, 24)) @(posedge clk);
      #2;
    end
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
